// File: rtl/diff_demo_pkg.sv
// Shared constants and FSM state type for the psum guard/pack block.
package diff_demo_pkg;

  localparam int LANES  = 6;
  localparam int PSUM_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/fm_guard_pack_if.sv
// Config, psum-beat and packed-output handshakes of fm_guard_pack.
interface fm_guard_pack_if #(
  parameter int LANES  = diff_demo_pkg::LANES,
  parameter int PSUM_W = diff_demo_pkg::PSUM_W
);

  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [3:0]                cfg_shift_i;
  logic                      cfg_bit_mode_i;
  logic                      cfg_is_diff_i;

  logic                      psum_valid;
  logic                      psum_ready;
  logic [LANES*PSUM_W-1:0]   psum_data;
  logic [2:0]                psum_lanes;
  logic                      psum_last;

  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*8-1:0]        out_data;
  logic [LANES-1:0]          out_guard;
  logic                      out_last;

  logic                      done;
  logic [15:0]               nz_total;

  modport master (
    output cfg_valid, cfg_shift_i, cfg_bit_mode_i, cfg_is_diff_i,
    input  cfg_ready,
    output psum_valid, psum_data, psum_lanes, psum_last,
    input  psum_ready,
    output out_ready,
    input  out_valid, out_data, out_guard, out_last,
    input  done, nz_total
  );

  modport slave (
    input  cfg_valid, cfg_shift_i, cfg_bit_mode_i, cfg_is_diff_i,
    output cfg_ready,
    input  psum_valid, psum_data, psum_lanes, psum_last,
    output psum_ready,
    input  out_ready,
    output out_valid, out_data, out_guard, out_last,
    output done, nz_total
  );

endinterface

// File: rtl/fm_pack_fifo.sv
// Two-entry FIFO; the head reads as zero while empty so outputs are clean after reset.
module fm_pack_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop  && (count != 2'd0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the empty-gated read below hides its power-up contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fm_guard_pack.sv
// Quantizes signed psum lanes (round, shift, optional ReLU, saturate), flags non-zero
// lanes and queues packed beats through a 2-entry FIFO, counting non-zero lanes per frame.
module fm_guard_pack #(
  parameter int LANES  = diff_demo_pkg::LANES,
  parameter int PSUM_W = diff_demo_pkg::PSUM_W
) (
  input  logic            clk,
  input  logic            rst,
  fm_guard_pack_if.slave  bus
);

  import diff_demo_pkg::state_e;
  import diff_demo_pkg::IDLE;
  import diff_demo_pkg::RUN;
  import diff_demo_pkg::DRAIN;

  localparam int QW    = PSUM_W + 2;
  localparam int PAY_W = LANES * 8 + LANES + 1;

  state_e             state;
  logic [3:0]         shift_q;
  logic               bit_mode_q;
  logic               is_diff_q;
  logic [15:0]        nz_q;

  logic [1:0]         fifo_count;
  logic [PAY_W-1:0]   fifo_head;
  logic               psum_accept;
  logic               out_pop;

  int                 lanes_req;
  int                 eff_lanes;
  logic [LANES*8-1:0] lane_data;
  logic [LANES-1:0]   lane_guard;
  logic [16:0]        nz_sum;

  // Two guard bits of headroom keep round-then-shift exact for any psum and shift.
  function automatic logic [7:0] quant_lane(
    input logic signed [PSUM_W-1:0] psum,
    input logic [3:0]               shift,
    input logic                     bit_mode,
    input logic                     is_diff
  );
    logic signed [QW-1:0] ext;
    logic signed [QW-1:0] rnd;
    logic signed [QW-1:0] q;
    logic signed [QW-1:0] hi;
    logic signed [QW-1:0] lo;
    ext = {{2{psum[PSUM_W-1]}}, psum};
    rnd = '0;
    if (shift != 4'd0) rnd[shift - 4'd1] = 1'b1;
    q   = (ext + rnd) >>> shift;
    if (!is_diff && q[QW-1]) q = '0;
    hi  = bit_mode ? QW'(7)  : QW'(127);
    lo  = bit_mode ? QW'(-8) : QW'(-128);
    if (q > hi)      q = hi;
    else if (q < lo) q = lo;
    return q[7:0];
  endfunction

  assign bus.cfg_ready  = (state == IDLE);
  assign bus.psum_ready = (state == RUN) && (fifo_count < 2'd2);
  assign bus.done       = (state == DRAIN) && (fifo_count == 2'd0);
  assign bus.nz_total   = nz_q;

  assign psum_accept = bus.psum_valid && bus.psum_ready;
  assign out_pop     = bus.out_valid && bus.out_ready;

  assign lanes_req = int'(bus.psum_lanes);
  assign eff_lanes = ((lanes_req == 0) || (lanes_req > LANES)) ? LANES : lanes_req;

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    lane_data  = '0;
    lane_guard = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < eff_lanes) begin
        lane_data[i*8 +: 8] = quant_lane(bus.psum_data[i*PSUM_W +: PSUM_W],
                                         shift_q, bit_mode_q, is_diff_q);
        lane_guard[i]       = (lane_data[i*8 +: 8] != 8'd0);
      end
    end
  end

  assign nz_sum = {1'b0, nz_q} + 17'($countones(lane_guard));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_q    <= 4'd0;
      bit_mode_q <= 1'b0;
      is_diff_q  <= 1'b0;
      nz_q       <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            shift_q    <= bus.cfg_shift_i;
            bit_mode_q <= bus.cfg_bit_mode_i;
            is_diff_q  <= bus.cfg_is_diff_i;
            nz_q       <= 16'd0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (psum_accept) begin
            nz_q <= nz_sum[16] ? 16'hFFFF : nz_sum[15:0];
            if (bus.psum_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_count == 2'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fm_pack_fifo #(
    .W (PAY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (psum_accept),
    .wr_data ({bus.psum_last, lane_guard, lane_data}),
    .pop     (out_pop),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  assign bus.out_valid = (fifo_count != 2'd0);
  assign bus.out_data  = fifo_head[LANES*8-1:0];
  assign bus.out_guard = fifo_head[LANES*8 +: LANES];
  assign bus.out_last  = fifo_head[PAY_W-1];

endmodule

// File: doc/fm_guard_pack.md
FM_GUARD_PACK -- requirements
Module: fm_guard_pack

Interface
REQ-001 Parameter LANES, default 6, SHALL set the number of psum lanes per beat.
REQ-002 Parameter PSUM_W, default 16, SHALL set the signed psum width per lane.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 cfg_valid / cfg_ready  in/out  1/1  SHALL be the frame config handshake.
REQ-006 cfg_shift_i  in  4  SHALL be the right-shift amount, 0..15.
REQ-007 cfg_bit_mode_i / cfg_is_diff_i  in  1/1  SHALL select 0=8-bit / 1=4-bit output, and 1=signed diff mode (no ReLU).
REQ-008 psum_valid / psum_ready  in/out  1/1  SHALL be the psum beat handshake.
REQ-009 psum_data  in  LANES*PSUM_W  SHALL carry signed psums; lane i at bits [i*PSUM_W +: PSUM_W].
REQ-010 psum_lanes  in  3  SHALL give the valid lane count 1..LANES, lanes 0..n-1 valid.
REQ-011 psum_last  in  1  SHALL mark the last beat of the frame.
REQ-012 out_valid / out_ready  out/in  1/1  SHALL be the packed-output handshake.
REQ-013 out_data / out_guard / out_last  out  LANES*8 / LANES / 1  SHALL carry the quantized lanes, non-zero flags and frame end.
REQ-014 done  out  1  SHALL be a one-cycle frame-complete pulse.
REQ-015 nz_total  out  16  SHALL hold the frame count of guard bits equal to 1.

Function
REQ-016 States SHALL be IDLE, RUN and DRAIN.
- IDLE->RUN on cfg accept.
- RUN->DRAIN on accept of a beat with psum_last=1.
- DRAIN->IDLE when the FIFO is empty, with done=1 in that cycle.
REQ-017 cfg_ready SHALL be 1 only in IDLE; the accept cycle latches shift, bit_mode and is_diff, and clears nz_total.
REQ-018 psum_ready SHALL be (state==RUN) && (fifo_count<2).
REQ-019 Per lane, the datapath SHALL compute q = (psum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, at 18-bit signed width with no overflow.
REQ-020 If is_diff=0, negative q SHALL become 0 (ReLU).
REQ-021 q SHALL saturate to [-128,127] for bit_mode=0, or to [-8,7] sign-extended to 8 bits for bit_mode=1.
REQ-022 guard[i] SHALL be (i<psum_lanes) && (q_sat!=0); lanes i>=psum_lanes SHALL output data 0 and guard 0.
REQ-023 A beat accepted at cycle N SHALL be written into a 2-entry FIFO at N+1; out_* SHALL present the FIFO head and out_valid = fifo_count!=0.
REQ-024 Simultaneous push and pop SHALL leave fifo_count unchanged; order SHALL be preserved.
REQ-025 When FIFO is full, the block SHALL not push and SHALL hold psum_ready=0.
REQ-026 nz_total SHALL add popcount(guard) on each FIFO push, saturating at 16'hFFFF.
REQ-027 nz_total SHALL hold its value from done until the next cfg accept.
REQ-028 psum_lanes of 0 or greater than LANES SHALL be treated as LANES.
REQ-029 out_data, out_guard and out_last SHALL remain stable while out_valid && !out_ready.

Reset
REQ-030 On rst=1 the block SHALL enter IDLE, empty the FIFO and clear all config registers.
REQ-031 On rst=1 the outputs SHALL be: cfg_ready=1, psum_ready=0, out_valid=0, out_data=0, out_guard=0, out_last=0, done=0, nz_total=0.
REQ-032 Reset mid-frame SHALL discard in-flight beats without asserting done.

Structure
REQ-033 LANES, PSUM_W and the state enum typedef SHALL reside in diff_demo_pkg.
REQ-034 The 2-entry FIFO SHALL be a sub-module named fm_pack_fifo, parameterised by payload width.

Verification
REQ-035 8-bit ReLU scenario:
- Stimulus: cfg shift=4, bit_mode=0, is_diff=0; one beat of lanes {100,-50,8,7,4096,0}, psum_lanes=6, last=1, out_ready=1.
- Required: out lanes {6,0,1,0,127,0}, guard=6'b010101, done two cycles after the FIFO push, nz_total=3.
REQ-036 4-bit diff scenario:
- Stimulus: cfg shift=0, bit_mode=1, is_diff=1; lanes {-20,5,-3,9,0,1}.
- Required: out lanes {-8,5,-3,7,0,1} sign-extended, guard=6'b101111.
REQ-037 Partial-lane scenario:
- Stimulus: psum_lanes=4 with all lanes = 32, shift=0.
- Required: lanes 4..5 data 0, guard=6'b001111.
REQ-038 Backpressure scenario:
- Stimulus: out_ready=0 and 3 beats offered.
- Required: psum_ready drops after 2 accepts; out_data stays stable; with out_ready=1 all 3 beats emerge in order and out_last is set only on the third.
REQ-039 Mid-frame reset scenario:
- Stimulus: rst pulsed in RUN with the FIFO holding 1 entry.
- Required: next cycle out_valid=0, cfg_ready=1, no done pulse.
